// File: rtl/jt49_div_multi.sv
// jt49_div_multi: CH independent tone/noise period dividers sharing one clock enable.
//
// Each channel has a double-buffered period: writes land in a shadow register.
// The shadow is copied into the active period only at a wrap or a restart, so a
// period change never cuts the half-period that is currently running.
// Each channel produces a 50 % square wave (div) and a one-clk wrap strobe (tick).
//
// Parameters:
//   CH  number of channels (>=1)
//   W   period/counter width in bits (>=2)
//   AW  write-address width (derived)
//
// Ports:
//   clk      core clock
//   rst      asynchronous active-high reset
//   cen      clock enable shared by all channels
//   wr_en    period write strobe, honoured on every clk edge regardless of cen
//   wr_addr  channel to write; addresses >= CH are ignored
//   wr_data  new period value
//   restart  per-channel phase restart, honoured on every clk edge
//   div      square-wave outputs
//   tick     one-clk pulse following the enabled edge on which a channel wraps
//
// Build option:
//   JT49_DIV_MULTI_RESTART_EN  when defined, restart is honoured; when undefined,
//                              the restart port exists but is ignored.

module jt49_div_multi #(
    parameter int CH = 3,
    parameter int W  = 12,
    localparam int AW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [CH-1:0] restart,
    output logic [CH-1:0] div,
    output logic [CH-1:0] tick
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] shadow_q;
        logic [W-1:0] active_q;
        logic [W-1:0] count_q;
        logic         div_q;
        logic         tick_q;
        logic         wr_hit;
        logic [W-1:0] next_period;

        // Only addresses 0..CH-1 can match, so out-of-range writes fall through.
        assign wr_hit      = wr_en && (wr_addr == AW'(i));
        // A write on the same edge as a wrap/restart bypasses the shadow.
        assign next_period = wr_hit ? wr_data : shadow_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q <= '0;
            end else if (wr_hit) begin
                shadow_q <= wr_data;
            end
        end

        // count restarts at 1 and active only changes when count is reloaded,
        // so count never exceeds max(active,1) and cannot overflow.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_q  <= W'(1);
                active_q <= '0;
                div_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else
`ifdef JT49_DIV_MULTI_RESTART_EN
            if (restart[i]) begin
                count_q  <= W'(1);
                active_q <= next_period;
                div_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else
`endif
            if (cen) begin
                // Period 0 behaves as 1: count (>=1) is always >= 0.
                if (count_q >= active_q) begin
                    count_q  <= W'(1);
                    active_q <= next_period;
                    div_q    <= ~div_q;
                    tick_q   <= 1'b1;
                end else begin
                    count_q  <= count_q + W'(1);
                    tick_q   <= 1'b0;
                end
            end else begin
                tick_q <= 1'b0;
            end
        end

        assign div[i]  = div_q;
        assign tick[i] = tick_q;
    end

`ifndef JT49_DIV_MULTI_RESTART_EN
    logic unused_restart;
    assign unused_restart = ^restart;
`endif

endmodule

// File: tb/tb_jt49_div_multi.sv
// Directed bench for jt49_div_multi (CH=3, W=12).
// Each phase pushes the clk cycle and div level of every expected tick into a
// per-channel queue; a negedge monitor pops one entry per observed tick.
// cyc counts rising clk edges, so a tick produced on edge n is seen at cyc==n.

module tb_jt49_div_multi;

    typedef struct {
        int   c;
        logic d;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       cen;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [11:0] wr_data;
    logic [2:0] restart;
    logic [2:0] div;
    logic [2:0] tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    jt49_div_multi #(.CH(3), .W(12)) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .restart (restart),
        .div     (div),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int ch, input int c, input logic d);
        exp_t e;
        e.c = c;
        e.d = d;
        case (ch)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every tick seen must match the head of that channel's queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (tick[i]) begin
                    exp_t e;
                    int   n;
                    n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
                    checks++;
                    if (n == 0) begin
                        errors++;
                        $display("FAIL tick_unexpected ch%0d: tick at cyc %0d, none expected", i, cyc);
                    end else begin
                        case (i)
                            0: e = q0.pop_front();
                            1: e = q1.pop_front();
                            default: e = q2.pop_front();
                        endcase
                        if (e.c != cyc || e.d != div[i]) begin
                            errors++;
                            $display("FAIL tick_ch%0d: got cyc %0d div %0b, expected cyc %0d div %0b",
                                     i, cyc, div[i], e.c, e.d);
                        end
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge with rst released and cen low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cen = 1'b0; wr_en = 1'b0; restart = '0;
        @(negedge clk);
        chk("reset_div", int'(div), 0);
        chk("reset_tick", int'(tick), 0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int b;

    initial begin
        rst = 1'b1; cen = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; restart = '0;

        // Phase 1: ch0=3, ch1=1, ch2=0, cen held high for 12 edges.
        do_reset();
        wr(2'd0, 12'd3); wr(2'd1, 12'd1); wr(2'd2, 12'd0);
        b = cyc;
        for (int k = 0; k < 4; k++) push_exp(0, b + 1 + 3 * k, (k % 2 == 0));
        for (int k = 1; k <= 12; k++) begin
            push_exp(1, b + k, (k % 2 == 1));
            push_exp(2, b + k, (k % 2 == 1));
        end
        cen = 1'b1;
        for (int k = 1; k <= 12; k++) @(negedge clk);
        cen = 1'b0;

        // Phase 2: ch0=4 with cen high one clk in three -> toggle every 12 clks.
        do_reset();
        wr(2'd0, 12'd4); wr(2'd1, 12'd100); wr(2'd2, 12'd100);
        b = cyc;
        for (int k = 0; k < 4; k++) push_exp(0, b + 1 + 12 * k, (k % 2 == 0));
        push_exp(1, b + 1, 1'b1);
        push_exp(2, b + 1, 1'b1);
        for (int m = 0; m < 15; m++) begin
            cen = 1'b1; @(negedge clk);
            cen = 1'b0; @(negedge clk); @(negedge clk);
        end

        // Phase 3: ch1=5, write 2 while count=2; current half-period keeps 5.
        do_reset();
        wr(2'd0, 12'd100); wr(2'd1, 12'd5); wr(2'd2, 12'd100);
        b = cyc;
        push_exp(0, b + 1, 1'b1);
        push_exp(2, b + 1, 1'b1);
        push_exp(1, b + 1, 1'b1);
        push_exp(1, b + 6, 1'b0);
        push_exp(1, b + 8, 1'b1);
        push_exp(1, b + 10, 1'b0);
        push_exp(1, b + 12, 1'b1);
        cen = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin wr_en = 1'b1; wr_addr = 2'd1; wr_data = 12'd2; end
            else wr_en = 1'b0;
            @(negedge clk);
        end
        cen = 1'b0; wr_en = 1'b0;

        // Phase 4: ch2=3, write 7 on its wrap edge; later a write to address 3.
        do_reset();
        wr(2'd0, 12'd100); wr(2'd1, 12'd100); wr(2'd2, 12'd3);
        b = cyc;
        push_exp(0, b + 1, 1'b1);
        push_exp(1, b + 1, 1'b1);
        push_exp(2, b + 1, 1'b1);
        push_exp(2, b + 4, 1'b0);
        push_exp(2, b + 11, 1'b1);
        push_exp(2, b + 18, 1'b0);
        cen = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4)      begin wr_en = 1'b1; wr_addr = 2'd2; wr_data = 12'd7; end
            else if (k == 6) begin wr_en = 1'b1; wr_addr = 2'd3; wr_data = 12'd1; end
            else wr_en = 1'b0;
            @(negedge clk);
        end
        cen = 1'b0; wr_en = 1'b0;

        // Phase 5: ch0=3, restart[0] while div0=1 and count0=2.
        do_reset();
        wr(2'd0, 12'd3); wr(2'd1, 12'd100); wr(2'd2, 12'd100);
        b = cyc;
        push_exp(1, b + 1, 1'b1);
        push_exp(2, b + 1, 1'b1);
        push_exp(0, b + 1, 1'b1);
`ifdef JT49_DIV_MULTI_RESTART_EN
        push_exp(0, b + 6, 1'b1);
        push_exp(0, b + 9, 1'b0);
        push_exp(0, b + 12, 1'b1);
`else
        push_exp(0, b + 4, 1'b0);
        push_exp(0, b + 7, 1'b1);
        push_exp(0, b + 10, 1'b0);
`endif
        cen = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            restart = (k == 3) ? 3'b001 : 3'b000;
            @(negedge clk);
            if (k == 3) begin
`ifdef JT49_DIV_MULTI_RESTART_EN
                chk("restart_div0", int'(div[0]), 0);
`else
                chk("restart_div0", int'(div[0]), 1);
`endif
            end
        end
        cen = 1'b0; restart = '0;

        // Phase 6: full-scale period 0xFFF on ch0/ch2, then async reset mid-run.
        do_reset();
        wr(2'd0, 12'hFFF); wr(2'd1, 12'd1); wr(2'd2, 12'hFFF);
        b = cyc;
        push_exp(0, b + 1, 1'b1);
        push_exp(0, b + 4096, 1'b0);
        push_exp(2, b + 1, 1'b1);
        push_exp(2, b + 4096, 1'b0);
        for (int k = 1; k <= 4101; k++) push_exp(1, b + k, (k % 2 == 1));
        cen = 1'b1;
        for (int k = 1; k <= 4101; k++) @(negedge clk);
        chk("prereset_div1", int'(div[1]), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_div", int'(div), 0);
        chk("async_reset_tick", int'(tick), 0);
        cen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // shadow and active must both be 0 again: every channel wraps each edge.
        b = cyc;
        for (int k = 1; k <= 3; k++)
            for (int ch = 0; ch < 3; ch++) push_exp(ch, b + k, (k % 2 == 1));
        cen = 1'b1;
        for (int k = 1; k <= 3; k++) @(negedge clk);
        cen = 1'b0;
        @(negedge clk);
        @(negedge clk);

        chk("leftover_ch0", q0.size(), 0);
        chk("leftover_ch1", q1.size(), 0);
        chk("leftover_ch2", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
